// File: rtl/edge_pkg.sv
// Shared definitions for the edge generator: FSM encoding and level constants.
package edge_pkg;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_HOLD  = 1'b1
    } state_t;

    localparam logic LVL_LOW  = 1'b0;
    localparam logic LVL_HIGH = 1'b1;

    localparam int HOLD_MIN = 1;
    localparam int HOLD_MAX = 255;

endpackage

// File: rtl/edge_gen_hold_timer.sv
// Hold timer: after load, expired rises exactly HOLD_CYCLES-1 cycles later.
import edge_pkg::*;

module hold_timer #(
    parameter int HOLD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);

    localparam int              W        = $clog2(HOLD_CYCLES + 1);
    localparam logic [W-1:0]    LOAD_VAL = W'(HOLD_CYCLES - 1);

    logic [W-1:0] r_cnt;

    // Saturating down-counter; the edge cycle itself counts as the first hold cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= LOAD_VAL;
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - W'(1);
        end
    end

    assign expired = (r_cnt == '0);

endmodule

// File: rtl/edge_gen.sv
// Edge generator: produces rate-limited rising/falling edges on out_s,
// with a one-deep pending slot for requests arriving during the hold time.
import edge_pkg::*;

module edge_gen #(
    parameter int   HOLD_CYCLES = 4,
    parameter logic INIT_LEVEL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic rise_req,
    input  logic fall_req,
    output logic out_s,
    output logic rise_done,
    output logic fall_done,
    output logic busy,
    output logic err_drop
);

    state_t r_state;
    logic   r_out;
    logic   r_pend;
    logic   r_rise_done;
    logic   r_fall_done;
    logic   r_busy;
    logic   r_err;

    logic   w_expired;
    logic   w_eff;
    logic   w_one;
    logic   w_lvl;
    logic   w_valid;
    logic   w_drop;
    logic   w_open;
    logic   w_fire;
    logic   w_store;
    logic   w_hold_nxt;

    hold_timer #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_hold_timer (
        .clk    (clk),
        .rst    (rst),
        .load   (w_fire),
        .expired(w_expired)
    );

    // A pending request always opposes out_s, so the new level is always ~r_out.
    always_comb begin
        w_eff      = r_pend ? ~r_out : r_out;
        w_one      = rise_req ^ fall_req;
        w_lvl      = rise_req;
        w_valid    = w_one && (w_lvl != w_eff) && !r_pend;
        w_drop     = (rise_req && fall_req)
                   || (w_one && (w_lvl == w_eff))
                   || (w_one && (w_lvl != w_eff) && r_pend);
        w_open     = (r_state == ST_READY) || w_expired;
        w_fire     = w_open && (r_pend || w_valid);
        w_store    = !w_open && w_valid;
        w_hold_nxt = w_fire || ((r_state == ST_HOLD) && !w_expired);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_READY;
            r_out       <= INIT_LEVEL;
            r_pend      <= 1'b0;
            r_rise_done <= 1'b0;
            r_fall_done <= 1'b0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_rise_done <= w_fire && (r_out == LVL_LOW);
            r_fall_done <= w_fire && (r_out == LVL_HIGH);
            r_err       <= w_drop;
            r_busy      <= w_hold_nxt;
            if (w_fire) begin
                r_out <= ~r_out;
            end
            if (w_fire) begin
                r_pend <= 1'b0;
            end else if (w_store) begin
                r_pend <= 1'b1;
            end
            unique case (r_state)
                ST_READY: if (w_fire) r_state <= ST_HOLD;
                ST_HOLD:  if (!w_hold_nxt) r_state <= ST_READY;
                default:  r_state <= ST_READY;
            endcase
        end
    end

    assign out_s     = r_out;
    assign rise_done = r_rise_done;
    assign fall_done = r_fall_done;
    assign busy      = r_busy;
    assign err_drop  = r_err;

endmodule

// File: tb/tb_edge_gen.sv
// Bench for edge_gen: directed table, HOLD_CYCLES=1 burst, random vs model.
module tb_edge_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst      = 1'b1;
    logic rise_req = 1'b0;
    logic fall_req = 1'b0;

    logic a_out, a_rd, a_fd, a_busy, a_err;
    logic b_out, b_rd, b_fd, b_busy, b_err;

    edge_gen #(.HOLD_CYCLES(4), .INIT_LEVEL(1'b0)) u_a (
        .clk(clk), .rst(rst), .rise_req(rise_req), .fall_req(fall_req),
        .out_s(a_out), .rise_done(a_rd), .fall_done(a_fd),
        .busy(a_busy), .err_drop(a_err)
    );

    edge_gen #(.HOLD_CYCLES(1), .INIT_LEVEL(1'b1)) u_b (
        .clk(clk), .rst(rst), .rise_req(rise_req), .fall_req(fall_req),
        .out_s(b_out), .rise_done(b_rd), .fall_done(b_fd),
        .busy(b_busy), .err_drop(b_err)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: an edge at cycle e forbids another edge before e+H.
    int       m_h[2]    = '{4, 1};
    bit       m_init[2] = '{1'b0, 1'b1};
    bit       m_lvl[2];
    bit       m_pend[2];
    int       m_last[2];
    logic [4:0] m_exp[2];

    task automatic model_step(input int d);
        bit eff, valid, drop, rd, fd, bsy, allowed;
        rd = 0; fd = 0; drop = 0; valid = 0;
        if (rst) begin
            m_lvl[d]  = m_init[d];
            m_pend[d] = 0;
            m_last[d] = -1000;
            m_exp[d]  = {m_init[d], 4'b0000};
        end else begin
            eff     = m_pend[d] ? !m_lvl[d] : m_lvl[d];
            allowed = (cyc + 1 - m_last[d]) >= m_h[d];
            if (rise_req && fall_req) drop = 1;
            else if (rise_req || fall_req) begin
                if (rise_req == eff) drop = 1;
                else if (m_pend[d]) drop = 1;
                else valid = 1;
            end
            if (allowed && (m_pend[d] || valid)) begin
                m_lvl[d]  = !m_lvl[d];
                m_pend[d] = 0;
                m_last[d] = cyc + 1;
                rd = m_lvl[d];
                fd = !m_lvl[d];
            end else if (valid) begin
                m_pend[d] = 1;
            end
            bsy = ((cyc + 1 - m_last[d]) < m_h[d]) || m_pend[d];
            m_exp[d] = {m_lvl[d], rd, fd, bsy, drop};
        end
    endtask

    function automatic logic [4:0] dut_vec(input int d);
        if (d == 0) return {a_out, a_rd, a_fd, a_busy, a_err};
        return {b_out, b_rd, b_fd, b_busy, b_err};
    endfunction

    task automatic check5(input string nm, input logic [4:0] act,
                          input logic [4:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%b required=%b", nm, cyc, act, exp);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        model_step(0);
        model_step(1);
        @(posedge clk);
        #1;
        cyc++;
        check5("model_a", dut_vec(0), m_exp[0]);
        check5("model_b", dut_vec(1), m_exp[1]);
    endtask

    typedef struct {
        logic       rs;
        logic       r;
        logic       f;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl[30];

    function automatic vec_t mk(input logic rs, input logic r, input logic f,
                                input logic [4:0] e);
        vec_t v;
        v.rs = rs; v.r = r; v.f = f; v.exp = e;
        return v;
    endfunction

    initial begin
        int nrise, nfall;
        logic prev;

        // expected = {out_s, rise_done, fall_done, busy, err_drop} next cycle
        tbl[0]  = mk(1, 0, 0, 5'b00000);
        tbl[1]  = mk(1, 0, 0, 5'b00000);
        tbl[2]  = mk(0, 1, 0, 5'b11010);
        tbl[3]  = mk(0, 0, 0, 5'b10010);
        tbl[4]  = mk(0, 0, 1, 5'b10010);
        tbl[5]  = mk(0, 0, 0, 5'b10010);
        tbl[6]  = mk(0, 0, 0, 5'b00110);
        tbl[7]  = mk(0, 0, 0, 5'b00010);
        tbl[8]  = mk(0, 0, 0, 5'b00010);
        tbl[9]  = mk(0, 0, 0, 5'b00010);
        tbl[10] = mk(0, 0, 0, 5'b00000);
        tbl[11] = mk(0, 1, 1, 5'b00001);
        tbl[12] = mk(0, 0, 1, 5'b00001);
        tbl[13] = mk(0, 1, 0, 5'b11010);
        tbl[14] = mk(0, 0, 1, 5'b10010);
        tbl[15] = mk(0, 0, 1, 5'b10011);
        tbl[16] = mk(0, 1, 0, 5'b10011);
        tbl[17] = mk(0, 0, 0, 5'b00110);
        tbl[18] = mk(0, 1, 0, 5'b00010);
        tbl[19] = mk(0, 1, 0, 5'b00011);
        tbl[20] = mk(0, 0, 0, 5'b00010);
        tbl[21] = mk(0, 0, 0, 5'b11010);
        tbl[22] = mk(0, 0, 0, 5'b10010);
        tbl[23] = mk(0, 0, 1, 5'b10010);
        tbl[24] = mk(1, 0, 0, 5'b00000);
        tbl[25] = mk(0, 0, 0, 5'b00000);
        tbl[26] = mk(0, 0, 0, 5'b00000);
        tbl[27] = mk(0, 0, 0, 5'b00000);
        tbl[28] = mk(1, 0, 0, 5'b00000);
        tbl[29] = mk(0, 1, 0, 5'b11010);

        for (int i = 0; i < 30; i++) begin
            rst      = tbl[i].rs;
            rise_req = tbl[i].r;
            fall_req = tbl[i].f;
            tick();
            check5($sformatf("table_row%0d", i), dut_vec(0), tbl[i].exp);
        end

        // HOLD_CYCLES=1 burst on u_b (INIT 1): fall, rise, fall, ...
        rst = 1; rise_req = 0; fall_req = 0;
        tick();
        tick();
        rst = 0;
        nrise = 0;
        nfall = 0;
        for (int i = 0; i < 8; i++) begin
            rise_req = (i % 2 == 1);
            fall_req = (i % 2 == 0);
            prev = b_out;
            tick();
            check5($sformatf("h1_toggle%0d", i), {4'b0000, b_out},
                   {4'b0000, ~prev});
            nrise += int'(b_rd);
            nfall += int'(b_fd);
        end
        rise_req = 0;
        fall_req = 0;
        tick();
        check_int("h1_rise_done_count", nrise, 4);
        check_int("h1_fall_done_count", nfall, 4);

        // Random traffic with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            rst      = ($urandom_range(0, 63) == 0);
            rise_req = ($urandom_range(0, 3) == 0);
            fall_req = ($urandom_range(0, 3) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/edge_gen.md
EDGE_GEN -- requirements
Module: edge_gen

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 4: minimum number of cycles out_s holds a level after any edge; legal range 1..255.
REQ-002 SHALL have parameter INIT_LEVEL, default 0: value of out_s after reset.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port rise_req, input, 1 bit: single-cycle request for a rising edge on out_s.
REQ-006 SHALL have port fall_req, input, 1 bit: single-cycle request for a falling edge on out_s.
REQ-007 SHALL have port out_s, output, 1 bit: generated level, driven directly from a register.
REQ-008 SHALL have port rise_done, output, 1 bit: one-cycle pulse in the cycle out_s first reads 1 after a rising edge.
REQ-009 SHALL have port fall_done, output, 1 bit: one-cycle pulse in the cycle out_s first reads 0 after a falling edge.
REQ-010 SHALL have port busy, output, 1 bit: high while the hold timer runs or a request is pending.
REQ-011 SHALL have port err_drop, output, 1 bit: one-cycle pulse when a request is discarded.

Function
REQ-012 SHALL implement a two-state FSM: READY (the next edge is allowed) and HOLD (hold timer running).
REQ-013 SHALL compute the effective level as the opposite of out_s when a request is pending, else out_s.
REQ-014 SHALL treat a request as valid only if exactly one of rise_req/fall_req is high and it opposes the effective level.
REQ-015 SHALL, for a valid request in READY with nothing pending, toggle out_s at the next edge (latency 1), pulse the matching *_done in that same cycle, and enter HOLD.
REQ-016 SHALL, on an edge, load the hold timer so that the earliest next edge occurs exactly HOLD_CYCLES cycles after this edge.
REQ-017 SHALL, for a valid request in HOLD with the pending slot empty, store it in a one-deep pending slot.
REQ-018 SHALL execute a pending request on the first cycle the hold expires, with no extra bubble, then clear the slot and reload the timer.
REQ-019 SHALL return from HOLD to READY when the timer expires and nothing is pending.
REQ-020 SHALL discard the request and pulse err_drop one cycle later when rise_req and fall_req are high together.
REQ-021 SHALL discard the request and pulse err_drop one cycle later for a request matching the effective level.
REQ-022 SHALL discard the request and pulse err_drop one cycle later for a valid request arriving while the pending slot is full.
REQ-023 SHALL, with HOLD_CYCLES=1, accept a valid request every cycle and toggle on consecutive cycles.
REQ-024 SHALL size the hold counter as $clog2(HOLD_CYCLES+1) bits, with no wrap: it saturates at 0.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, set out_s=INIT_LEVEL, rise_done=0, fall_done=0, err_drop=0, busy=0, FSM=READY, timer=0, and pending cleared.
REQ-026 SHALL give rst priority over all requests; reset mid-hold discards the pending request without pulsing err_drop.
REQ-027 SHALL accept a valid request in the first cycle after rst deasserts.

Structure
REQ-028 SHALL place the FSM state encoding (READY, HOLD) in shared package edge_pkg, alongside the edge-detector constants.
REQ-029 SHALL place the hold counter in sub-module hold_timer (inputs load/clk/rst, output expired), parameterized by HOLD_CYCLES.
REQ-030 SHALL be implementable in 120-400 lines of RTL, with all outputs registered.

Verification
REQ-031 SHALL verify: reset, then rise_req at cycle 2 -> out_s=1 and rise_done=1 at cycle 3, busy=1 for cycles 3..6.
REQ-032 SHALL verify: HOLD_CYCLES=4, rise at cycle 2, fall_req at cycle 4 -> fall stored as pending, out_s=0 and fall_done=1 at cycle 7, no err_drop.
REQ-033 SHALL verify: rise_req and fall_req both high at cycle 2 -> out_s unchanged, err_drop=1 at cycle 3.
REQ-034 SHALL verify: out_s=0 with a rise pending, then rise_req again -> err_drop=1 on the following cycle, and only one rising edge is produced.
REQ-035 SHALL verify: HOLD_CYCLES=1, alternating rise/fall requests on cycles 2..9 -> out_s toggles every cycle, 4 rise_done and 4 fall_done pulses.
REQ-036 SHALL verify: rst asserted while HOLD with a pending request -> out_s=INIT_LEVEL, busy=0, and no edge or err_drop afterward.
